// File: rtl/fnorm_fu_if.sv
// Handshake and payload bundle for the fnorm_fu normalise/round/pack stage.
// master drives the input beat and out_ready; slave is the fnorm_fu side.
interface fnorm_fu_if #(
    parameter int unsigned TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             sign_in;
    logic [6:0]       exponent_in;
    logic [17:0]      mantissa_in;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [17:0]      result;
    logic [TAG_W-1:0] tag_out;
    logic             overflow;
    logic             inexact;

    modport master (
        output in_valid, sign_in, exponent_in, mantissa_in, tag_in, out_ready,
        input  in_ready, out_valid, result, tag_out, overflow, inexact
    );

    modport slave (
        input  in_valid, sign_in, exponent_in, mantissa_in, tag_in, out_ready,
        output in_ready, out_valid, result, tag_out, overflow, inexact
    );
endinterface

// File: rtl/fnorm_fu.sv
// fnorm_fu: 3-stage normalise / round / pack pipeline behind the FADD/FSUB/CVTIF unit.
// Output format: {sign, biased-63 exponent[6:0], fraction[9:0]}.
// Optional macro FNORM_RNE_EN: round-to-nearest-even; when undefined, results truncate.
// Upstream cannot stall, so issue logic must hold one credit per beat it sends here;
// in_ready only tells that logic when the three buffer slots are all occupied.
module fnorm_fu #(
    parameter int unsigned TAG_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    fnorm_fu_if.slave   bus
);
    localparam int unsigned MANT_W  = 18;
    localparam int unsigned EXP_W   = 7;
    localparam int unsigned FRAC_W  = 10;
    localparam int unsigned POS_W   = 5;
    localparam int unsigned EW_W    = 8;
    localparam int unsigned NORM_W  = MANT_W - 1;
    localparam int unsigned GRD_BIT = NORM_W - 1 - FRAC_W;
    localparam int unsigned EXP_SAT = 127;
    localparam int unsigned RES_W   = 1 + EXP_W + FRAC_W;
`ifdef FNORM_RNE_EN
    localparam int unsigned FSUM_W  = FRAC_W + 1;
`endif

    logic v0, v1, v2;
    logic ld0, ld1, ld2;

    // Stage load enables: a stage loads when empty or when its successor is loading.
    always_comb begin
        ld2 = !v2 || bus.out_ready;
        ld1 = !v1 || ld2;
        ld0 = !v0 || ld1;
    end

    assign bus.in_ready = ld0;

    // ---------------- Stage 0: leading-one detect ----------------
    logic [POS_W-1:0]  lod_p;
    logic [MANT_W-1:0] s0_m;
    logic [POS_W-1:0]  s0_p;
    logic              s0_zero;
    logic              s0_sign;
    logic [EXP_W-1:0]  s0_exp;
    logic [TAG_W-1:0]  s0_tag;

    // Position of the highest set mantissa bit (0 when the mantissa is zero).
    always_comb begin
        lod_p = '0;
        for (int i = 0; i < int'(MANT_W); i++) begin
            if (bus.mantissa_in[i]) begin
                lod_p = POS_W'(i);
            end
        end
    end

    // Stage 0 register: capture the accepted beat with its leading-one position.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0      <= 1'b0;
            s0_m    <= '0;
            s0_p    <= '0;
            s0_zero <= 1'b0;
            s0_sign <= 1'b0;
            s0_exp  <= '0;
            s0_tag  <= '0;
        end else if (ld0) begin
            v0 <= bus.in_valid;
            if (bus.in_valid) begin
                s0_m    <= bus.mantissa_in;
                s0_p    <= lod_p;
                s0_zero <= (bus.mantissa_in == '0);
                s0_sign <= bus.sign_in;
                s0_exp  <= bus.exponent_in;
                s0_tag  <= bus.tag_in;
            end
        end
    end

    // ---------------- Stage 1: normalising shift ----------------
    logic [NORM_W-1:0] norm;
    logic [EW_W-1:0]   e_sum;
    logic [EW_W-1:0]   s1_e;
    logic [FRAC_W-1:0] s1_frac;
    logic              s1_guard;
    logic              s1_sticky;
    logic              s1_zero;
    logic              s1_sign;
    logic [TAG_W-1:0]  s1_tag;

    // Shift the leading one up to bit 17 and drop it; what remains is frac|guard|sticky.
    always_comb begin
        norm  = NORM_W'(s0_m << (POS_W'(MANT_W - 1) - s0_p));
        e_sum = EW_W'(s0_exp) + EW_W'(s0_p);
    end

    // Stage 1 register: biased exponent, fraction and rounding bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            s1_e      <= '0;
            s1_frac   <= '0;
            s1_guard  <= 1'b0;
            s1_sticky <= 1'b0;
            s1_zero   <= 1'b0;
            s1_sign   <= 1'b0;
            s1_tag    <= '0;
        end else if (ld1) begin
            v1 <= v0;
            if (v0) begin
                s1_e      <= e_sum;
                s1_frac   <= norm[NORM_W-1 -: FRAC_W];
                s1_guard  <= norm[GRD_BIT];
                s1_sticky <= |norm[GRD_BIT-1:0];
                s1_zero   <= s0_zero;
                s1_sign   <= s0_sign;
                s1_tag    <= s0_tag;
            end
        end
    end

    // ---------------- Stage 2: round and pack ----------------
    logic [FRAC_W-1:0] frac_rnd;
    logic [EW_W-1:0]   e_rnd;
    logic [RES_W-1:0]  nxt_res;
    logic              nxt_ovf;
    logic              nxt_inx;
    logic [RES_W-1:0]  res_q;
    logic [TAG_W-1:0]  tag_q;
    logic              ovf_q;
    logic              inx_q;

`ifdef FNORM_RNE_EN
    logic              round_up;
    logic [FSUM_W-1:0] frac_sum;

    // Round to nearest even; a fraction carry bumps the exponent.
    always_comb begin
        round_up = s1_guard && (s1_sticky || s1_frac[0]);
        frac_sum = FSUM_W'(s1_frac) + FSUM_W'(round_up);
        frac_rnd = frac_sum[FRAC_W-1:0];
        e_rnd    = s1_e + EW_W'(frac_sum[FRAC_W]);
    end
`else
    // Truncate: the discarded bits only feed the inexact flag.
    always_comb begin
        frac_rnd = s1_frac;
        e_rnd    = s1_e;
    end
`endif

    // Special-case selection: zero, then saturate to infinity, then flush, else normal.
    always_comb begin
        nxt_res = {s1_sign, e_rnd[EXP_W-1:0], frac_rnd};
        nxt_ovf = 1'b0;
        nxt_inx = s1_guard || s1_sticky;
        if (s1_zero) begin
            nxt_res = '0;
            nxt_inx = 1'b0;
        end else if (e_rnd >= EW_W'(EXP_SAT)) begin
            nxt_res = {s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            nxt_ovf = 1'b1;
        end else if (e_rnd == '0) begin
            nxt_res = {s1_sign, {(RES_W-1){1'b0}}};
            nxt_inx = 1'b1;
        end
    end

    // Output register: holds its beat until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2    <= 1'b0;
            res_q <= '0;
            tag_q <= '0;
            ovf_q <= 1'b0;
            inx_q <= 1'b0;
        end else if (ld2) begin
            v2 <= v1;
            if (v1) begin
                res_q <= nxt_res;
                tag_q <= s1_tag;
                ovf_q <= nxt_ovf;
                inx_q <= nxt_inx;
            end
        end
    end

    assign bus.out_valid = v2;
    assign bus.result    = res_q;
    assign bus.tag_out   = tag_q;
    assign bus.overflow  = ovf_q;
    assign bus.inexact   = inx_q;

endmodule

// File: tb/tb_fnorm_fu.sv
// Self-checking bench for fnorm_fu: vector table, backpressure, mid-flight reset,
// and a randomised throttled run, all checked through an in-order scoreboard.
module tb_fnorm_fu;
    localparam int unsigned TAG_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fnorm_fu_if #(.TAG_W(TAG_W)) bus ();
    fnorm_fu #(.TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [17:0]      res;
        logic [TAG_W-1:0] tag;
        logic             ovf;
        logic             inx;
    } exp_t;

    typedef struct {
        logic        s;
        logic [6:0]  e;
        logic [17:0] m;
        logic [17:0] res;
        logic        ovf;
        logic        inx;
    } vec_t;

    exp_t             sb[$];
    exp_t             cur_exp;
    exp_t             got_exp;
    logic [TAG_W-1:0] next_tag = '0;
    int               n_tests = 0;
    int               n_fail = 0;
    int               n_out = 0;
    logic             prev_stall = 1'b0;
    logic [24:0]      held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Reference: normalise with plain integer arithmetic, then round/saturate/flush.
    function automatic exp_t model(input logic s, input logic [6:0] e, input logic [17:0] m);
        exp_t r;
        int p, ee, frac, g, st, rem;
        r.res = '0; r.tag = '0; r.ovf = 1'b0; r.inx = 1'b0;
        if (m == 18'h0) return r;
        p = 0;
        for (int i = 17; i >= 0; i--) begin
            if (m[i] && p == 0 && (int'(m) >> i) == 1) p = i;
        end
        ee = int'(e) + p;
        g = 0; st = 0;
        if (p <= 10) begin
            frac = (int'(m) << (10 - p)) & 'h3FF;
        end else begin
            frac = (int'(m) >> (p - 10)) & 'h3FF;
            rem  = int'(m) & ((1 << (p - 10)) - 1);
            g    = (rem >> (p - 11)) & 1;
            st   = ((rem & ((1 << (p - 11)) - 1)) != 0) ? 1 : 0;
        end
`ifdef FNORM_RNE_EN
        if (g == 1 && (st == 1 || (frac & 1) == 1)) begin
            frac++;
            if (frac == 1024) begin
                frac = 0;
                ee++;
            end
        end
`endif
        r.inx = (g != 0) || (st != 0);
        if (ee >= 127) begin
            r.res = {s, 7'h7F, 10'h0};
            r.ovf = 1'b1;
        end else if (ee == 0) begin
            r.res = {s, 17'h0};
            r.inx = 1'b1;
        end else begin
            r.res = {s, 7'(ee), 10'(frac)};
        end
        return r;
    endfunction

    // Negedge monitor: scoreboard pop on output transfer, push on input acceptance, hold check.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_stable", 32'({bus.out_valid, bus.result, bus.tag_out, bus.overflow, bus.inexact}),
                      32'(held));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got result %h tag %h, required no beat",
                             bus.result, bus.tag_out);
                end else begin
                    got_exp = sb.pop_front();
                    n_out++;
                    check($sformatf("beat_tag%0h", got_exp.tag),
                          32'({bus.result, bus.tag_out, bus.overflow, bus.inexact}),
                          32'({got_exp.res, got_exp.tag, got_exp.ovf, got_exp.inx}));
                end
            end
            if (bus.in_valid && bus.in_ready) sb.push_back(cur_exp);
            prev_stall = bus.out_valid && !bus.out_ready;
            held = {1'b1, bus.result, bus.tag_out, bus.overflow, bus.inexact};
        end
    end

    // Present one beat (call at posedge+1); the expectation travels with it.
    task automatic drive(input logic s, input logic [6:0] e, input logic [17:0] m, input exp_t x);
        bus.sign_in     = s;
        bus.exponent_in = e;
        bus.mantissa_in = m;
        bus.tag_in      = next_tag;
        cur_exp         = x;
        cur_exp.tag     = next_tag;
        next_tag        = next_tag + 1'b1;
        bus.in_valid    = 1'b1;
    endtask

    // Hold the beat until accepted, then return at posedge+1 with in_valid low.
    task automatic wait_accept();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Send one beat into an idle pipe and measure cycles until out_valid.
    task automatic send_and_time(input logic s, input logic [6:0] e, input logic [17:0] m, input exp_t x);
        int lat;
        lat = 0;
        drive(s, e, m, x);
        @(negedge clk);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
        check("latency", 32'(lat), 32'd3);
    endtask

    vec_t vt[15];
    exp_t xe;
    int   out_base;
    logic rnd_done;

    initial begin
        bus.in_valid    = 1'b0;
        bus.sign_in     = 1'b0;
        bus.exponent_in = '0;
        bus.mantissa_in = '0;
        bus.tag_in      = '0;
        bus.out_ready   = 1'b1;
        xe.res = '0; xe.tag = '0; xe.ovf = 1'b0; xe.inx = 1'b0;

        vt[0]  = '{1'b0, 7'd53,  18'h00400, 18'h0FC00, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 7'd63,  18'h00005, 18'h10500, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 7'd53,  18'h00800, 18'h10000, 1'b0, 1'b0};
`ifdef FNORM_RNE_EN
        vt[3]  = '{1'b0, 7'd53,  18'h01006, 18'h10402, 1'b0, 1'b1};
        vt[7]  = '{1'b0, 7'd46,  18'h3FFFF, 18'h10000, 1'b0, 1'b1};
        vt[8]  = '{1'b0, 7'd109, 18'h3FFFF, 18'h1FC00, 1'b1, 1'b1};
`else
        vt[3]  = '{1'b0, 7'd53,  18'h01006, 18'h10401, 1'b0, 1'b1};
        vt[7]  = '{1'b0, 7'd46,  18'h3FFFF, 18'h0FFFF, 1'b0, 1'b1};
        vt[8]  = '{1'b0, 7'd109, 18'h3FFFF, 18'h1FBFF, 1'b0, 1'b1};
`endif
        vt[4]  = '{1'b0, 7'd127, 18'h00400, 18'h1FC00, 1'b1, 1'b0};
        vt[5]  = '{1'b1, 7'd40,  18'h00000, 18'h00000, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 7'd0,   18'h00001, 18'h00000, 1'b0, 1'b1};
        vt[9]  = '{1'b1, 7'd116, 18'h00400, 18'h3F800, 1'b0, 1'b0};
        vt[10] = '{1'b1, 7'd117, 18'h00400, 18'h3FC00, 1'b1, 1'b0};
        vt[11] = '{1'b0, 7'd53,  18'h01002, 18'h10400, 1'b0, 1'b1};
        vt[12] = '{1'b0, 7'd1,   18'h00001, 18'h00400, 1'b0, 1'b0};
        vt[13] = '{1'b1, 7'd0,   18'h00001, 18'h20000, 1'b0, 1'b1};
        vt[14] = '{1'b0, 7'd127, 18'h3FFFF, 18'h1FC00, 1'b1, 1'b1};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_result",    32'(bus.result),    32'd0);
        check("rst_tag_out",   32'(bus.tag_out),   32'd0);
        check("rst_overflow",  32'(bus.overflow),  32'd0);
        check("rst_inexact",   32'(bus.inexact),   32'd0);
        @(posedge clk);
        #1;

        // Single beat latency on the 1.0 case.
        xe.res = vt[0].res; xe.ovf = vt[0].ovf; xe.inx = vt[0].inx;
        send_and_time(vt[0].s, vt[0].e, vt[0].m, xe);
        drain();

        // Vector table, back to back.
        for (int i = 0; i < 15; i++) begin
            xe.res = vt[i].res; xe.ovf = vt[i].ovf; xe.inx = vt[i].inx;
            drive(vt[i].s, vt[i].e, vt[i].m, xe);
            wait_accept();
        end
        drain();

        // Backpressure: 5 beats, out_ready low across six clock edges.
        out_base = n_out;
        bus.out_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            drive(1'b0, 7'(60 + b), 18'(18'h00401 + 18'(b)), model(1'b0, 7'(60 + b), 18'(18'h00401 + 18'(b))));
            wait_accept();
        end
        drive(1'b1, 7'd70, 18'h2A5A5, model(1'b1, 7'd70, 18'h2A5A5));
        @(negedge clk);
        check("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        repeat (2) begin
            @(negedge clk);
            check("bp_in_ready_stall", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_accept();
        drive(1'b0, 7'd20, 18'h00003, model(1'b0, 7'd20, 18'h00003));
        wait_accept();
        drain();
        check("bp_beats_out", 32'(n_out - out_base), 32'd5);

        // Reset with three beats in flight.
        for (int b = 0; b < 3; b++) begin
            drive(1'b0, 7'd63, 18'(b + 1), model(1'b0, 7'd63, 18'(b + 1)));
            wait_accept();
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk);
        #1;
        out_base = n_out;
        send_and_time(1'b1, 7'd63, 18'h00005, model(1'b1, 7'd63, 18'h00005));
        drain();
        repeat (4) begin
            @(negedge clk);
            check("midrst_alone", 32'(bus.out_valid), 32'd0);
        end
        check("midrst_beats_out", 32'(n_out - out_base), 32'd1);
        @(posedge clk);
        #1;

        // Random beats with random gaps and random consumer throttling.
        rnd_done = 1'b0;
        fork
            begin
                logic [17:0] rm;
                logic [6:0]  re;
                logic        rs;
                for (int k = 0; k < 30; k++) begin
                    rm = 18'($urandom) & 18'((1 << $urandom_range(1, 18)) - 1);
                    re = 7'($urandom);
                    rs = 1'($urandom);
                    drive(rs, re, rm, model(rs, re, rm));
                    wait_accept();
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
